// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the serial pattern detector:
//   - MAXLEN       : widest pattern / history supported (bits)
//   - state_e      : controller state encoding (IDLE, RUN, DONE)
//   - DEF_*        : configuration loaded by reset ("110", overlap on, 256-bit frame)
//   - frame_bits() : turns the 8-bit frame field into a bit count (0 -> 256)
// -----------------------------------------------------------------------------
package seq_det_pkg;

  localparam int MAXLEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [MAXLEN-1:0] DEF_PATTERN = 8'h06;
  localparam logic [2:0]        DEF_LEN     = 3'd2;
  localparam logic              DEF_OVERLAP = 1'b1;
  localparam logic [7:0]        DEF_FRAME   = 8'd0;

  // A frame field of zero stands for the full 256-bit frame.
  function automatic logic [8:0] frame_bits(input logic [7:0] frame);
    if (frame == 8'd0) begin
      return 9'd256;
    end
    return {1'b0, frame};
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// -----------------------------------------------------------------------------
// seq_det_if
// Control, configuration and data bundle of the sequence detector.
//   master : drives cfg_*, start, abort, x_valid, x_in; observes status
//   slave  : the detector; drives busy, done, match, match_cnt
//
// Handshake: x_valid qualifies x_in for one cycle. There is no ready signal
// and no backpressure: a bit is consumed on every x_valid cycle while busy is
// high, and is silently dropped whenever busy is low or abort is high in the
// same cycle. start, abort and cfg_wr are single-cycle level strobes that are
// only acted on in the state where they are meaningful.
// -----------------------------------------------------------------------------
interface seq_det_if #(
  parameter int MAXLEN = 8
);

  logic              cfg_wr;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [2:0]        cfg_len;
  logic              cfg_overlap;
  logic [7:0]        cfg_frame;
  logic              start;
  logic              abort;
  logic              x_valid;
  logic              x_in;
  logic              busy;
  logic              done;
  logic              match;
  logic [7:0]        match_cnt;

  modport master (
    output cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_frame,
    output start, abort, x_valid, x_in,
    input  busy, done, match, match_cnt
  );

  modport slave (
    input  cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_frame,
    input  start, abort, x_valid, x_in,
    output busy, done, match, match_cnt
  );

endinterface

// File: rtl/seq_match_core.sv
// -----------------------------------------------------------------------------
// seq_match_core
// Bit history, fill counter and pattern comparison.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : empty the history at the start of a run
//   shift_en  : a bit is being consumed this cycle
//   bit_in    : the bit being consumed
//   pattern   : pattern, bit [len] compared against the oldest bit
//   len       : pattern length minus one
//   overlap   : 1 = keep fill after a match, 0 = require fresh bits
//   hit       : combinational, the bit being consumed completes a match
// -----------------------------------------------------------------------------
module seq_match_core #(
  parameter int MAXLEN = seq_det_pkg::MAXLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [2:0]        len,
  input  logic              overlap,
  output logic              hit
);

  localparam int FW = $clog2(MAXLEN + 1);

  logic [MAXLEN-1:0] hist_q;
  logic [MAXLEN-1:0] hist_d;
  logic [MAXLEN-1:0] mask;
  logic [FW-1:0]     fill_q;
  logic [FW-1:0]     fill_d;
  logic [FW-1:0]     pat_bits;

  // Newest bit enters at position 0.
  assign hist_d   = {hist_q[MAXLEN-2:0], bit_in};
  assign fill_d   = (fill_q == FW'(MAXLEN)) ? fill_q : fill_q + FW'(1);
  assign pat_bits = FW'(len) + FW'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (i <= int'(len));
    end
  end

  // Compare against the history as it will be after this shift.
  assign hit = shift_en && (fill_d >= pat_bits) &&
               ((hist_d & mask) == (pattern & mask));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_d;
      fill_q <= (hit && !overlap) ? '0 : fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Framed serial pattern detector: counts occurrences of a configurable
// 1..8-bit pattern in a run of cfg_frame bits (0 = 256).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (loads default config)
//   bus       : seq_det_if slave (config, start/abort, serial data, status)
//   state_dbg : current controller state (seq_det_pkg::state_e encoding)
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int MAXLEN = seq_det_pkg::MAXLEN
) (
  input  logic        clk,
  input  logic        rst,
  seq_det_if.slave    bus,
  output logic [1:0]  state_dbg
);

  import seq_det_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic [MAXLEN-1:0] pat_q;
  logic [2:0]        len_q;
  logic              ovl_q;
  logic [7:0]        frame_q;
  logic [8:0]        bit_cnt_q;
  logic [7:0]        match_cnt_q;
  logic              match_q;

  logic              accept_bit;
  logic              run_clear;
  logic              last_bit;
  logic              hit;

  // Abort in the same cycle discards the bit, including the final one.
  assign accept_bit = (state_q == RUN) && !bus.abort && bus.x_valid;
  assign run_clear  = (state_q == IDLE) && bus.start;
  assign last_bit   = accept_bit && ((bit_cnt_q + 9'd1) == frame_bits(frame_q));

  seq_match_core #(
    .MAXLEN (MAXLEN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (run_clear),
    .shift_en (accept_bit),
    .bit_in   (bus.x_in),
    .pattern  (pat_q),
    .len      (len_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= DEF_PATTERN;
      len_q       <= DEF_LEN;
      ovl_q       <= DEF_OVERLAP;
      frame_q     <= DEF_FRAME;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= accept_bit && hit;
      // Written together with start, the new config governs the new run.
      if ((state_q == IDLE) && bus.cfg_wr) begin
        pat_q   <= bus.cfg_pattern;
        len_q   <= bus.cfg_len;
        ovl_q   <= bus.cfg_overlap;
        frame_q <= bus.cfg_frame;
      end
      if (run_clear) begin
        bit_cnt_q   <= '0;
        match_cnt_q <= '0;
      end else if (accept_bit) begin
        bit_cnt_q <= bit_cnt_q + 9'd1;
        if (hit && (match_cnt_q != 8'hFF)) begin
          match_cnt_q <= match_cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.match     = match_q;
  assign bus.match_cnt = match_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAXLEN, default 8, maximum pattern length in bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cfg_wr  input  1  load cfg_pattern/cfg_len/cfg_overlap/cfg_frame; honoured only in IDLE.
REQ-005 cfg_pattern  input  MAXLEN  pattern; bit [L-1] matched first, bit 0 matched last.
REQ-006 cfg_len  input  3  pattern length minus 1 (L = cfg_len+1, range 1..8).
REQ-007 cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-008 cfg_frame  input  8  bits per run; 0 means 256.
REQ-009 start  input  1  begin a run; honoured only in IDLE.
REQ-010 abort  input  1  terminate a run; honoured only in RUN.
REQ-011 x_valid  input  1  x_in carries a bit this cycle.
REQ-012 x_in  input  1  serial data bit.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse at normal end of run.
REQ-015 match  output  1  one-cycle pulse per detected pattern.
REQ-016 match_cnt  output  8  matches in current or last run, saturating.

Function
REQ-017 FSM states: IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-018 IDLE->RUN on start; entry clears history, fill count, bit count, match_cnt.
REQ-019 cfg_wr and start in the same IDLE cycle: both accepted; the run uses the newly written configuration.
REQ-020 cfg_wr outside IDLE, start outside IDLE, abort outside RUN: ignored, no side effect.
REQ-021 In RUN, each x_valid=1 cycle shifts x_in into an 8-bit history (newest at bit 0), increments fill (saturating at 8) and bit count; x_valid=0 cycles change nothing.
REQ-022 Match condition on a sampled bit: fill after shift >= L and history[L-1:0] == cfg_pattern[L-1:0].
REQ-023 match is registered: high in the cycle following the edge that sampled the completing bit, for one cycle.
REQ-024 Overlap=1: fill unaffected by match; overlap=0: fill cleared on match so the next match needs L fresh bits.
REQ-025 match_cnt increments by 1 per match, holds at 255.
REQ-026 RUN->DONE on the edge sampling bit number frame (cfg_frame, or 256 if 0); a match on that bit is still reported and counted.
REQ-027 done = (state==DONE); busy = (state==RUN); no bits consumed outside RUN.
REQ-028 abort in RUN: next state IDLE, no done; a bit presented the same cycle is discarded; match_cnt retained.
REQ-029 abort on the final-bit cycle: abort wins; no done, final bit not counted.
REQ-030 match_cnt holds its value in IDLE/DONE until the next start.

Reset
REQ-031 rst forces: state IDLE, busy 0, done 0, match 0, match_cnt 0, history 0, fill 0, bit count 0.
REQ-032 rst loads default config: pattern 8'h06, cfg_len 2 (pattern "110"), overlap 1, frame 0 (256).
REQ-033 rst has priority over all inputs including cfg_wr and start; rst mid-run discards the run without done.

Structure
REQ-034 Package seq_det_pkg holds the state encoding (IDLE, RUN, DONE), MAXLEN, and the reset-default config constants.
REQ-035 Sub-module seq_match_core holds history, fill and comparison; seq_det_ctrl holds FSM, config registers, bit and match counters.

Verification
REQ-036 After reset, start, frame=6, bits 1,1,0,1,1,0 -> match pulses after bits 3 and 6, match_cnt=2, done one cycle after bit 6.
REQ-037 Pattern 2'b11 (len 2), frame=4, bits 1,1,1,1: overlap=1 -> match_cnt=3; overlap=0 -> match_cnt=2.
REQ-038 x_valid gaps of 3 idle cycles between bits of "110" -> same single match; busy stays high throughout.
REQ-039 abort asserted with the 4th of 6 bits -> IDLE next cycle, no done, match_cnt reflects bits 1-3 only; start while busy ignored.
REQ-040 Pattern 1'b1 (len 1), frame=0, 300 ones -> run ends after 256 bits, match_cnt=255 saturated; rst mid-run -> all outputs 0, config back to "110".
